// File: rtl/em_mem_if.sv
// E/M stage bus: E-stage results flowing into the M stage and the
// M-stage results flowing out to the M/W register and forwarding network.
// The bus is a plain per-cycle transfer with no valid/ready pair. Occupancy
// is controlled by the en/flush pipeline controls on the stage itself.
interface em_mem_if;
   // E-stage side
   logic [31:0] instr_E;
   logic [31:0] pc_E;
   logic [31:0] alu_C_E;
   logic [31:0] rt_E;
   logic        cal_overflow_E;
   logic [4:0]  exc_code_E;
   // M-stage side
   logic [31:0] instr_M;
   logic [31:0] pc_M;
   logic [31:0] alu_M;
   logic [31:0] rdata_M;
   logic [4:0]  exc_code_M;
   logic        mem_we;
   logic [3:0]  byte_en;

   modport master (
      output instr_E, pc_E, alu_C_E, rt_E, cal_overflow_E, exc_code_E,
      input  instr_M, pc_M, alu_M, rdata_M, exc_code_M, mem_we, byte_en
   );

   modport slave (
      input  instr_E, pc_E, alu_C_E, rt_E, cal_overflow_E, exc_code_E,
      output instr_M, pc_M, alu_M, rdata_M, exc_code_M, mem_we, byte_en
   );
endinterface

// File: rtl/em_mem_stage.sv
// E/M pipeline register, M-stage data memory and load/store unit.
// Registers the E-stage result, performs word/half/byte stores into the
// data memory, returns extended load data and raises AdEL/AdES for CP0.
module em_mem_stage #(
   parameter int DM_WORDS = 3072
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic flush,
   input  logic exc_int,
   em_mem_if.slave bus
);
   localparam int          IDX_W    = $clog2(DM_WORDS);
   localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic [31:0] alu_q;
   logic [31:0] rt_q;
   logic        ovf_q;
   logic [4:0]  exc_q;

   logic [31:0] mem [DM_WORDS];

   logic [5:0]       op;
   logic             is_word, is_half, is_byte;
   logic             is_load, is_store, is_signed;
   logic             in_range, misalign, addr_bad;
   logic [4:0]       own_exc, exc_out;
   logic [IDX_W-1:0] word_idx;
   logic [31:0]      rd_word, wdata, rdata;
   logic [3:0]       be;
   logic             we;

   // E/M register: reset > flush > hold > load. A flush keeps pc so EPC stays valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= '0;
         pc_q    <= '0;
         alu_q   <= '0;
         rt_q    <= '0;
         ovf_q   <= 1'b0;
         exc_q   <= '0;
      end else if (flush) begin
         instr_q <= '0;
         pc_q    <= bus.pc_E;
         alu_q   <= '0;
         rt_q    <= '0;
         ovf_q   <= 1'b0;
         exc_q   <= '0;
      end else if (en) begin
         instr_q <= bus.instr_E;
         pc_q    <= bus.pc_E;
         alu_q   <= bus.alu_C_E;
         rt_q    <= bus.rt_E;
         ovf_q   <= bus.cal_overflow_E;
         exc_q   <= bus.exc_code_E;
      end
   end

   // Opcode decode, address checks and exception code selection.
   always_comb begin
      op        = instr_q[31:26];
      is_word   = (op == OP_LW) || (op == OP_SW);
      is_half   = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      is_byte   = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
      is_load   = (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
                  (op == OP_LB) || (op == OP_LBU);
      is_store  = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
      is_signed = (op == OP_LH) || (op == OP_LB);
      in_range  = (alu_q < DM_BYTES);
      misalign  = (is_word && (alu_q[1:0] != 2'b00)) || (is_half && alu_q[0]);
      addr_bad  = misalign || !in_range || ovf_q;
      own_exc   = 5'd0;
      if (is_load && addr_bad)
         own_exc = EXC_ADEL;
      else if (is_store && addr_bad)
         own_exc = EXC_ADES;
      exc_out   = (exc_q != 5'd0) ? exc_q : own_exc;
      word_idx  = alu_q[IDX_W+1:2];
   end

   // Byte lanes and replicated write data for stores.
   always_comb begin
      be    = 4'b0000;
      wdata = rt_q;
      if (is_store && is_word) begin
         be    = 4'b1111;
         wdata = rt_q;
      end else if (is_store && is_half) begin
         be    = alu_q[1] ? 4'b1100 : 4'b0011;
         wdata = {2{rt_q[15:0]}};
      end else if (is_store && is_byte) begin
         be    = 4'b0001 << alu_q[1:0];
         wdata = {4{rt_q[7:0]}};
      end
      we = is_store && (exc_out == 5'd0) && !exc_int;
   end

   // Data memory: cleared on reset, otherwise enabled lanes written on a committed store.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DM_WORDS; i++)
            mem[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < 4; b++)
            if (be[b])
               mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   // Load path: out-of-range addresses never index the array.
   always_comb begin
      rd_word = in_range ? mem[word_idx] : 32'd0;
      rdata   = 32'd0;
      if (is_load && (exc_out == 5'd0)) begin
         if (is_word)
            rdata = rd_word;
         else if (is_half) begin
            if (alu_q[1])
               rdata = {{16{is_signed & rd_word[31]}}, rd_word[31:16]};
            else
               rdata = {{16{is_signed & rd_word[15]}}, rd_word[15:0]};
         end else begin
            case (alu_q[1:0])
               2'd0:    rdata = {{24{is_signed & rd_word[7]}},  rd_word[7:0]};
               2'd1:    rdata = {{24{is_signed & rd_word[15]}}, rd_word[15:8]};
               2'd2:    rdata = {{24{is_signed & rd_word[23]}}, rd_word[23:16]};
               default: rdata = {{24{is_signed & rd_word[31]}}, rd_word[31:24]};
            endcase
         end
      end
   end

   assign bus.instr_M    = instr_q;
   assign bus.pc_M       = pc_q;
   assign bus.alu_M      = alu_q;
   assign bus.exc_code_M = exc_out;
   assign bus.rdata_M    = rdata;
   assign bus.mem_we     = we;
   assign bus.byte_en    = be;
endmodule

// File: tb/tb_em_mem_stage.sv
// Bench for em_mem_stage: directed scenarios followed by random traffic,
// every cycle compared against a byte-addressed reference model.
module tb_em_mem_stage;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam int         MEM_BYTES = 12288;

   logic clk = 1'b0;
   logic reset, en, flush, exc_int;

   em_mem_if bus ();

   em_mem_stage #(.DM_WORDS(3072)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .flush   (flush),
      .exc_int (exc_int),
      .bus     (bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_err  = 0;

   // reference model state
   logic [7:0]  mm [MEM_BYTES];
   logic [31:0] m_instr, m_pc, m_alu, m_rt;
   logic        m_ovf;
   logic [4:0]  m_exc;
   logic        e_we;
   logic [3:0]  e_be;
   logic [31:0] pc_ctr = 32'h0000_3000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   // size in bytes (0 = not a memory op), load/store, signedness
   task automatic classify(input logic [5:0] op, output int sz, output bit ld, output bit st,
                           output bit sg);
      sz = 0; ld = 0; st = 0; sg = 0;
      case (op)
         OP_LW:  begin sz = 4; ld = 1; end
         OP_LH:  begin sz = 2; ld = 1; sg = 1; end
         OP_LHU: begin sz = 2; ld = 1; end
         OP_LB:  begin sz = 1; ld = 1; sg = 1; end
         OP_LBU: begin sz = 1; ld = 1; end
         OP_SW:  begin sz = 4; st = 1; end
         OP_SH:  begin sz = 2; st = 1; end
         OP_SB:  begin sz = 1; st = 1; end
         default: ;
      endcase
   endtask

   task automatic model_clear();
      for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;
      m_instr = 0; m_pc = 0; m_alu = 0; m_rt = 0; m_ovf = 0; m_exc = 0;
   endtask

   // scoreboard: compare every M-stage output against the model
   task automatic check_outputs();
      int sz; bit ld, st, sg, bad;
      logic [4:0]  x;
      logic [31:0] rd;
      int off;
      classify(m_instr[31:26], sz, ld, st, sg);
      bad = ((sz == 4) && (m_alu % 4 != 0)) || ((sz == 2) && (m_alu % 2 != 0)) ||
            (m_alu >= 32'h3000) || m_ovf;
      if (m_exc != 0)      x = m_exc;
      else if (ld && bad)  x = 5'd4;
      else if (st && bad)  x = 5'd5;
      else                 x = 5'd0;
      rd = 0;
      if (ld && x == 0) begin
         for (int k = 0; k < sz; k++) rd = rd | (32'(mm[m_alu + k]) << (8 * k));
         if (sg && sz < 4 && rd[8*sz-1]) rd = rd | ~((32'd1 << (8 * sz)) - 1);
      end
      e_be = 4'b0000;
      if (st) begin
         off  = int'(m_alu[1:0]) & ~(sz - 1);
         e_be = 4'(((1 << sz) - 1) << off);
      end
      e_we = st && (x == 0) && !exc_int;
      check("instr_M", bus.instr_M, m_instr);
      check("pc_M", bus.pc_M, m_pc);
      check("alu_M", bus.alu_M, m_alu);
      check("exc_code_M", 32'(bus.exc_code_M), 32'(x));
      check("rdata_M", bus.rdata_M, rd);
      check("mem_we", 32'(bus.mem_we), 32'(e_we));
      check("byte_en", 32'(bus.byte_en), 32'(e_be));
   endtask

   // model of the clock edge: commit store, then update the M registers
   task automatic model_edge();
      int sz; bit ld, st, sg;
      logic [31:0] base;
      classify(m_instr[31:26], sz, ld, st, sg);
      if (e_we) begin
         base = m_alu & ~32'd3;
         for (int j = 0; j < 4; j++)
            if (e_be[j])
               mm[base + j] = 8'(m_rt >> (8 * ((sz == 4) ? j : (sz == 2) ? (j % 2) : 0)));
      end
      if (flush) begin
         m_instr = 0; m_pc = bus.pc_E; m_alu = 0; m_rt = 0; m_ovf = 0; m_exc = 0;
      end else if (en) begin
         m_instr = bus.instr_E; m_pc = bus.pc_E; m_alu = bus.alu_C_E;
         m_rt = bus.rt_E; m_ovf = bus.cal_overflow_E; m_exc = bus.exc_code_E;
      end
   endtask

   // driver: one full cycle, inputs applied just after an edge
   task automatic step(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] rt,
                       input logic ovf, input logic [4:0] exc, input logic e, input logic f,
                       input logic xi);
      bus.instr_E = instr; bus.pc_E = pc_ctr; bus.alu_C_E = addr; bus.rt_E = rt;
      bus.cal_overflow_E = ovf; bus.exc_code_E = exc;
      en = e; flush = f; exc_int = xi;
      pc_ctr = pc_ctr + 4;
      #3;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic mem_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt);
      step({op, 26'h0}, addr, rt, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      model_clear();
      #1;
      reset = 1'b0;
      bus.instr_E = 0;
      check_outputs();
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; flush = 1'b0; exc_int = 1'b0;
      bus.instr_E = 0; bus.pc_E = 0; bus.alu_C_E = 0; bus.rt_E = 0;
      bus.cal_overflow_E = 0; bus.exc_code_E = 0;
      model_clear();
      e_we = 0; e_be = 0;
      @(posedge clk);
      do_reset();

      // word round trip
      mem_op(OP_SW, 32'h4, 32'h1234_5678);
      check("tp_sw_we", 32'(bus.mem_we), 32'd1);
      check("tp_sw_be", 32'(bus.byte_en), 32'hF);
      mem_op(OP_LW, 32'h4, 32'h0);
      check("tp_lw_data", bus.rdata_M, 32'h1234_5678);
      check("tp_lw_we", 32'(bus.mem_we), 32'd0);

      // byte store and extended loads
      do_reset();
      mem_op(OP_SB, 32'h7, 32'h0000_0080);
      mem_op(OP_LB, 32'h7, 32'h0);
      check("tp_lb", bus.rdata_M, 32'hFFFF_FF80);
      mem_op(OP_LBU, 32'h7, 32'h0);
      check("tp_lbu", bus.rdata_M, 32'h0000_0080);
      mem_op(OP_LW, 32'h4, 32'h0);
      check("tp_lw_b", bus.rdata_M, 32'h8000_0000);

      // half store and extended load
      mem_op(OP_SH, 32'h2, 32'h0000_BEEF);
      check("tp_sh_be", 32'(bus.byte_en), 32'hC);
      mem_op(OP_LH, 32'h2, 32'h0);
      check("tp_lh", bus.rdata_M, 32'hFFFF_BEEF);

      // misaligned / out of range
      mem_op(OP_SH, 32'h1, 32'h0000_5555);
      check("tp_sh_ades", 32'(bus.exc_code_M), 32'd5);
      check("tp_sh_we", 32'(bus.mem_we), 32'd0);
      mem_op(OP_LW, 32'h0, 32'h0);
      check("tp_unchanged", bus.rdata_M, 32'hBEEF_0000);
      mem_op(OP_LW, 32'h3000, 32'h0);
      check("tp_oor_exc", 32'(bus.exc_code_M), 32'd4);
      check("tp_oor_rd", bus.rdata_M, 32'h0);

      // overflow and upstream code
      step({OP_LW, 26'h0}, 32'h8, 32'h0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      check("tp_ovf", 32'(bus.exc_code_M), 32'd4);
      step({OP_LW, 26'h0}, 32'h9, 32'h0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
      check("tp_upstream", 32'(bus.exc_code_M), 32'd10);

      // store suppressed by exc_int
      mem_op(OP_SW, 32'h4, 32'hCAFE_F00D);
      step({OP_LW, 26'h0}, 32'h4, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      check("tp_excint_keep", bus.rdata_M, 32'h8000_0000);

      // flush and stall (with flush beating en=0)
      step({OP_LW, 26'h0}, 32'hC, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      check("tp_flush_instr", bus.instr_M, 32'h0);
      check("tp_flush_pc", bus.pc_M, pc_ctr - 4);
      mem_op(OP_LW, 32'h10, 32'h0);
      for (int i = 0; i < 3; i++)
         step({OP_SB, 26'h0}, 32'h20, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      check("tp_stall_alu", bus.alu_M, 32'h10);

      // reset while a store sits in M
      mem_op(OP_SW, 32'h8, 32'hDEAD_BEEF);
      do_reset();
      mem_op(OP_LW, 32'h8, 32'h0);
      check("tp_reset_drop", bus.rdata_M, 32'h0);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         logic [5:0]  op;
         logic [31:0] a;
         int r;
         if ($urandom_range(0, 149) == 0) do_reset();
         r = $urandom_range(0, 9);
         case (r)
            0: op = OP_LW;  1: op = OP_LH;  2: op = OP_LHU; 3: op = OP_LB;
            4: op = OP_LBU; 5: op = OP_SW;  6: op = OP_SH;  7: op = OP_SB;
            8: op = 6'h00;  default: op = 6'h0f;
         endcase
         r = $urandom_range(0, 15);
         if (r < 12)      a = 32'($urandom_range(0, 31));
         else if (r < 14) a = 32'h2FF8 + 32'($urandom_range(0, 15));
         else             a = $urandom;
         step({op, 26'($urandom)}, a, $urandom,
              1'($urandom_range(0, 19) == 0),
              ($urandom_range(0, 19) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
              1'($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 11) == 0),
              1'($urandom_range(0, 9) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/em_mem_stage.md
# em_mem_stage

E/M pipeline register plus the M-stage data memory and load/store unit of the MIPS pipeline. Captures the E-stage result each cycle, including the ALU result, forwarded rt data and the ALU overflow flag. It then performs word/half/byte stores into a 3072-word data memory, returns extended load data, and raises address exceptions (AdEL/AdES) toward CP0. Sits directly downstream of the ALU/MD stage; its outputs feed the M/W register and the forwarding network.

## Interface
- DM_WORDS, 3072, data memory depth in 32-bit words (byte range 0x0000_0000–0x0000_2FFF)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  E/M register enable; 0 = hold (stall)
- flush  in  1  load bubble into E/M register
- exc_int  in  1  CP0 is taking an exception/interrupt this cycle; suppresses any M-stage store
- instr_E  in  32  instruction in E
- pc_E  in  32  PC of instruction in E
- alu_C_E  in  32  ALU result (effective address for loads/stores)
- rt_E  in  32  forwarded rt value (store data)
- cal_overflow_E  in  1  ALU overflow flag of the E instruction
- exc_code_E  in  5  exception code already pending from upstream (0 = none)
- instr_M, pc_M, alu_M  out  32 each  registered copies
- rdata_M  out  32  load data, sign/zero extended
- exc_code_M  out  5  exception code for CP0 (0 none, 4 AdEL, 5 AdES)
- mem_we  out  1  store actually committed at next edge
- byte_en  out  4  byte lanes written (bit i = addr byte i)

## Operation
- Decoding uses instr_M[31:26]: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000. All other opcodes are non-memory.
- Register update on each posedge, priority reset > flush > !en > load.
  - Load: copies instr/pc/alu/rt/overflow/exc_code from the E-stage inputs.
  - Flush: instr_M=0 (nop), exc=0, overflow=0, pc_M=pc_E so the EPC stays valid.
  - Hold: all registers are unchanged.
- Let addr = alu_M. Word index = addr[13:2].
- Load exception (code 4) if any of the following:
  - lw and addr[1:0]≠0
  - lh/lhu and addr[0]≠0
  - addr ≥ 0x3000
  - overflow_M=1
- Store exception (code 5): same conditions for sw/sh/sb.
- exc_code_M = upstream code if it is nonzero; otherwise the own AdEL/AdES code; otherwise 0.
- byte_en:
  - sw: 1111.
  - sh: 0011 if addr[1]=0, else 1100.
  - sb: one-hot at addr[1:0].
  - Non-stores: 0000.
- mem_we = store & exc_code_M==0 & !exc_int. byte_en is still driven when mem_we=0, but has no effect.
- Write data lanes:
  - sw writes rt_M.
  - sh replicates rt_M[15:0] into both halves.
  - sb replicates rt_M[7:0] into all four bytes.
  - Only the enabled lanes are modified.
- rdata_M is combinational from the word read at addr.
  - lw: the whole word.
  - lh/lhu: the half selected by addr[1], sign- or zero-extended.
  - lb/lbu: the byte selected by addr[1:0], sign- or zero-extended.
  - Non-loads and excepting loads: 0.
- Address out of range: no memory access; the index is never used to read or write beyond DM_WORDS.

## Timing
- Reset: all E/M registers, instr_M, pc_M, alu_M and exc_code_M go to 0. rdata_M=0, mem_we=0, byte_en=0. All memory words are cleared to 0 in the same edge.
- E→M latency is 1 cycle. The store commits at the posedge that ends the M cycle.
- Load data is valid combinationally in the same M cycle.
- A lw immediately following a sw to the same word, in the next cycle, reads the new data.
- Stall: while en=0 with the same store held in M, the write repeats each edge (idempotent) unless exc_int is asserted.
- flush and en=0 in the same cycle: flush wins.
- reset mid-store: the write is dropped and memory is cleared.

## Test plan
- Word round trip: sw 0x12345678 to addr 0x0004, then lw 0x0004 → rdata_M=0x12345678, mem_we=1 for exactly one cycle, byte_en=1111.
- Byte store and extended loads: sb 0x80 to addr 0x0007, then lb → 0xFFFFFF80, lbu → 0x00000080, lw 0x0004 → 0x80000000.
- Half store and extended load: sh 0xBEEF to addr 0x0002, then lh → 0xFFFFBEEF, byte_en=1100.
- Misaligned and out-of-range accesses:
  - sh to 0x0001 → exc_code_M=5, mem_we=0, memory unchanged.
  - lw 0x3000 → exc_code_M=4, rdata_M=0.
- Overflow and upstream code:
  - lw with cal_overflow_E=1 → exc_code_M=4.
  - exc_code_E=10 with a misaligned lw → exc_code_M=10.
- Control interactions:
  - sw in M with exc_int=1 → mem_we=0, word unchanged.
  - flush → instr_M=0 with pc_M=pc_E.
  - en=0 for 3 cycles → instr_M, pc_M, alu_M unchanged.
